touch_spi_reader: RTL and testbench

- Upstream front-end for the on-screen square hit-test blocks.
- Drives an XPT2046-compatible resistive touch controller over SPI mode 0, reading 12-bit X and Y conversions while the pen is down.
- Publishes debounced `x_touch`, `y_touch` and `active`, which all square hit-test instances consume directly.

---
 rtl/touch_spi_reader.sv | 218 +++++++++++++++++++++
 tb/tb_touch_spi_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_spi_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | touch_spi_reader                                                             |
// | Polls an XPT2046-style touch controller over SPI mode 0, debounces pen-down. |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module touch_spi_reader #(
    parameter int CLK_DIV     = 25,
    parameter int SAMPLE_GAP  = 50000,
    parameter int PRESS_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        penirq_n,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic [11:0] x_touch,
    output logic [11:0] y_touch,
    output logic        active,
    output logic        sample_valid
);

    localparam int c_gap_max = (SAMPLE_GAP > 2 * CLK_DIV) ? SAMPLE_GAP : 2 * CLK_DIV;
    localparam int c_tw      = $clog2(c_gap_max + 1);
    localparam int c_dw      = $clog2(CLK_DIV);
    localparam int c_pw      = $clog2(PRESS_COUNT + 1);

    localparam logic [c_tw-1:0] c_gap_last   = c_tw'(SAMPLE_GAP - 1);
    localparam logic [c_tw-1:0] c_csgap_last = c_tw'(2 * CLK_DIV - 1);
    localparam logic [c_dw-1:0] c_div_last   = c_dw'(CLK_DIV - 1);
    localparam logic [c_pw-1:0] c_press_full = c_pw'(PRESS_COUNT);
    localparam logic [5:0]      c_half_last  = 6'd48;
    localparam logic [5:0]      c_half_d11   = 6'd19;
    localparam logic [5:0]      c_half_d0    = 6'd41;
    localparam logic [7:0]      c_cmd_x      = 8'hD0;
    localparam logic [7:0]      c_cmd_y      = 8'h90;

    typedef enum logic [2:0] {
        ST_GAP    = 3'd0,
        ST_XFER_X = 3'd1,
        ST_CSGAP  = 3'd2,
        ST_XFER_Y = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [c_tw-1:0]  timer_q, timer_d;
    logic [c_dw-1:0]  div_q, div_d;
    logic [5:0]       half_q, half_d;
    logic [11:0]      shreg_q, shreg_d;
    logic [11:0]      x_raw_q, x_raw_d;
    logic [c_pw-1:0]  press_q, press_d;
    logic [11:0]      x_touch_q, x_touch_d;
    logic [11:0]      y_touch_q, y_touch_d;
    logic             active_q, active_d;
    logic             sample_valid_q, sample_valid_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;

    logic             pen_meta_q, pen_sync_q;
    logic             miso_meta_q, miso_sync_q;

    logic             w_pen_down;
    logic [c_pw-1:0]  w_press_inc;
    logic             w_in_xfer;
    logic [7:0]       w_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pen_meta_q  <= 1'b1;
            pen_sync_q  <= 1'b1;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            pen_meta_q  <= penirq_n;
            pen_sync_q  <= pen_meta_q;
            miso_meta_q <= spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign w_pen_down  = ~pen_sync_q;
    assign w_press_inc = (press_q == c_press_full) ? press_q : press_q + c_pw'(1);

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        div_d          = div_q;
        half_d         = half_q;
        shreg_d        = shreg_q;
        x_raw_d        = x_raw_q;
        press_d        = press_q;
        x_touch_d      = x_touch_q;
        y_touch_d      = y_touch_q;
        active_d       = active_q;
        sample_valid_d = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (timer_q == c_gap_last) begin
                    timer_d = '0;
                    if (w_pen_down) begin
                        state_d = ST_XFER_X;
                    end else begin
                        press_d  = '0;
                        active_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + c_tw'(1);
                end
            end

            ST_XFER_X, ST_XFER_Y: begin
                // Sample one clock into the high phase so the synchroniser has settled.
                if (half_q[0] && (div_q == '0) && (half_q >= c_half_d11) && (half_q <= c_half_d0)) begin
                    shreg_d = {shreg_q[10:0], miso_sync_q};
                end
                if (div_q == c_div_last) begin
                    div_d = '0;
                    if (half_q == c_half_last) begin
                        half_d = '0;
                        if (state_q == ST_XFER_X) begin
                            x_raw_d = shreg_q;
                            state_d = ST_CSGAP;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        half_d = half_q + 6'd1;
                    end
                end else begin
                    div_d = div_q + c_dw'(1);
                end
            end

            ST_CSGAP: begin
                if (timer_q == c_csgap_last) begin
                    timer_d = '0;
                    state_d = ST_XFER_Y;
                end else begin
                    timer_d = timer_q + c_tw'(1);
                end
            end

            ST_CHECK: begin
                state_d = ST_GAP;
                if (!w_pen_down) begin
                    press_d  = '0;
                    active_d = 1'b0;
                end else begin
                    press_d = w_press_inc;
                    if (w_press_inc == c_press_full) begin
                        x_touch_d      = x_raw_q;
                        y_touch_d      = shreg_q;
                        active_d       = 1'b1;
                        sample_valid_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_GAP;
        endcase

        // SPI pins are registered from the next-state view so they stay glitch-free.
        w_in_xfer = (state_d == ST_XFER_X) || (state_d == ST_XFER_Y);
        w_cmd     = (state_d == ST_XFER_X) ? c_cmd_x : c_cmd_y;
        sclk_d    = w_in_xfer && half_d[0];
        cs_n_d    = ~w_in_xfer;
        mosi_d    = w_in_xfer && (half_d < 6'd16) && w_cmd[3'd7 - half_d[3:1]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_GAP;
            timer_q        <= '0;
            div_q          <= '0;
            half_q         <= '0;
            shreg_q        <= '0;
            x_raw_q        <= '0;
            press_q        <= '0;
            x_touch_q      <= '0;
            y_touch_q      <= '0;
            active_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            cs_n_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            div_q          <= div_d;
            half_q         <= half_d;
            shreg_q        <= shreg_d;
            x_raw_q        <= x_raw_d;
            press_q        <= press_d;
            x_touch_q      <= x_touch_d;
            y_touch_q      <= y_touch_d;
            active_q       <= active_d;
            sample_valid_q <= sample_valid_d;
            sclk_q         <= sclk_d;
            mosi_q         <= mosi_d;
            cs_n_q         <= cs_n_d;
        end
    end

    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;
    assign x_touch      = x_touch_q;
    assign y_touch      = y_touch_q;
    assign active       = active_q;
    assign sample_valid = sample_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_spi_reader.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_touch_spi_reader                                                          |
// | Directed bench with an XPT2046-style SPI responder for touch_spi_reader.     |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_touch_spi_reader;

    localparam int CLK_DIV     = 4;
    localparam int SAMPLE_GAP  = 100;
    localparam int PRESS_COUNT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        penirq_n = 1'b1;
    logic        spi_miso = 1'b0;
    logic        spi_sclk, spi_mosi, spi_cs_n;
    logic [11:0] x_touch, y_touch;
    logic        active, sample_valid;

    int n_cmp = 0;
    int n_err = 0;

    touch_spi_reader #(
        .CLK_DIV     (CLK_DIV),
        .SAMPLE_GAP  (SAMPLE_GAP),
        .PRESS_COUNT (PRESS_COUNT)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .penirq_n     (penirq_n),
        .spi_miso     (spi_miso),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .x_touch      (x_touch),
        .y_touch      (y_touch),
        .active       (active),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // Touch-controller responder: commands on edges 1..8, D11..D0 after falls 9..20.
    int          edge_cnt = 0;
    int          last_edges = 0;
    int          bad_period = 0;
    time         last_rise = 0;
    logic [7:0]  cmd_rx = 8'h00;
    logic [7:0]  cmd_log[$];
    logic [11:0] bfm_x = 12'h5A3;
    logic [11:0] bfm_y = 12'h21C;
    logic [11:0] bfm_data;

    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            last_edges = edge_cnt;
            edge_cnt   = 0;
        end else begin
            edge_cnt++;
            if (edge_cnt > 1 && ($time - last_rise) != 80) bad_period++;
            last_rise = $time;
            if (edge_cnt <= 8) begin
                cmd_rx = {cmd_rx[6:0], spi_mosi};
                if (edge_cnt == 8) cmd_log.push_back(cmd_rx);
            end
        end
    end

    always @(negedge spi_sclk) begin
        bfm_data = (cmd_rx == 8'hD0) ? bfm_x : ((cmd_rx == 8'h90) ? bfm_y : 12'h000);
        if (!spi_cs_n && edge_cnt >= 9 && edge_cnt <= 20)
            spi_miso = bfm_data[20 - edge_cnt];
        else
            spi_miso = 1'b0;
    end

    int n_pulse = 0;
    int n_wide = 0;
    bit prev_valid = 1'b0;
    bit active_seen = 1'b0;
    bit cs_low_seen = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sample_valid) n_pulse++;
        if (sample_valid && prev_valid) n_wide++;
        prev_valid = sample_valid;
        if (active) active_seen = 1'b1;
        if (!spi_cs_n) cs_low_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n0;
        int np;
        logic [7:0] c0, c1;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_x", x_touch, 12'h000);
        chk("rst_y", y_touch, 12'h000);
        chk("rst_active", active, 1'b0);
        chk("rst_valid", sample_valid, 1'b0);
        rst_n = 1'b1;
        cs_low_seen = 1'b0;
        repeat (120) @(negedge clk);
        chk("idle_cs_never_low", cs_low_seen, 1'b0);
        chk("idle_sclk", spi_sclk, 1'b0);
        chk("idle_active", active, 1'b0);

        // Basic press
        penirq_n = 1'b0;
        wait_valid(2000, ok);
        chk("press_valid_seen", ok, 1'b1);
        chk("press_active", active, 1'b1);
        chk("press_x", x_touch, 12'h5A3);
        chk("press_y", y_touch, 12'h21C);
        chk("press_frames", cmd_log.size(), 6);
        c0 = (cmd_log.size() > 0) ? cmd_log[0] : 8'h00;
        c1 = (cmd_log.size() > 1) ? cmd_log[1] : 8'h00;
        chk("cmd_x", c0, 8'hD0);
        chk("cmd_y", c1, 8'h90);
        chk("edges_per_frame", last_edges, 24);
        @(negedge clk);
        chk("valid_one_cycle", sample_valid, 1'b0);
        wait_valid(800, ok);
        chk("repeat_valid_seen", ok, 1'b1);
        repeat (2) @(negedge clk);
        chk("repeat_pulses", n_pulse, 2);

        // Lift during XFER_Y
        np = n_pulse;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!spi_cs_n && edge_cnt == 12 && cmd_rx == 8'h90) begin
                ok = 1'b1;
                break;
            end
        end
        chk("lift_found_xfer_y", ok, 1'b1);
        penirq_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_cs_n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("lift_frame_ends", ok, 1'b1);
        chk("lift_frame_edges", last_edges, 24);
        repeat (5) @(negedge clk);
        chk("lift_active", active, 1'b0);
        chk("lift_x_hold", x_touch, 12'h5A3);
        chk("lift_y_hold", y_touch, 12'h21C);
        chk("lift_no_pulse", n_pulse, np);

        // Two good pairs, lifted before the third check
        n0 = cmd_log.size();
        np = n_pulse;
        active_seen = 1'b0;
        penirq_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_log.size() >= n0 + 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("glitch_third_x", ok, 1'b1);
        penirq_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_active_never", active_seen, 1'b0);
        chk("glitch_no_pulse", n_pulse, np);
        chk("glitch_frames", cmd_log.size(), n0 + 6);

        // Extreme codes
        bfm_x = 12'hFFF;
        bfm_y = 12'h000;
        penirq_n = 1'b0;
        wait_valid(2000, ok);
        chk("ext_valid_seen", ok, 1'b1);
        chk("ext_x", x_touch, 12'hFFF);
        chk("ext_y", y_touch, 12'h000);
        chk("ext_active", active, 1'b1);

        // Reset in the middle of an X frame
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!spi_cs_n && edge_cnt == 13 && cmd_rx == 8'hD0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_found_xfer_x", ok, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_cs_n", spi_cs_n, 1'b1);
        chk("mid_sclk", spi_sclk, 1'b0);
        chk("mid_mosi", spi_mosi, 1'b0);
        chk("mid_x", x_touch, 12'h000);
        chk("mid_active", active, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmd_log.delete();
        active_seen = 1'b0;
        repeat (900) @(negedge clk);
        chk("post_active_never", active_seen, 1'b0);
        chk("post_x_zero", x_touch, 12'h000);
        chk("post_y_zero", y_touch, 12'h000);
        c0 = (cmd_log.size() > 0) ? cmd_log[0] : 8'h00;
        chk("post_first_cmd", c0, 8'hD0);
        wait_valid(1500, ok);
        chk("post_valid_seen", ok, 1'b1);
        chk("post_x", x_touch, 12'hFFF);

        chk("valid_never_wide", n_wide, 0);
        chk("sck_period_80ns", bad_period, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
